// File: rtl/key_scan_pulse.sv
// Three-line key scanner with per-key debounce and one-cycle press strobes.
// Define KEY_AUTOREPEAT_EN to add held-key repeat pulses (REPEAT_DELAY / REPEAT_RATE frames).
module key_scan_pulse #(
   parameter int N_KEYS      = 3,
   parameter int SCAN_DIV    = 1000,
   parameter int DEB_SAMPLES = 8
`ifdef KEY_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_sense,
   output logic [N_KEYS-1:0] o_scan,
   output logic [N_KEYS-1:0] o_key_state,
   output logic [N_KEYS-1:0] o_key_pulse,
   output logic              o_frame
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DEB_SAMPLES);
   localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] SLOT_PRE  = CW'(SCAN_DIV - 2);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_SAMPLES - 1);

   typedef enum logic [1:0] {
      SLOT0 = 2'd0,
      SLOT1 = 2'd1,
      SLOT2 = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [CW-1:0]     slot_cnt_reg, slot_cnt_next;
   logic [N_KEYS-1:0] scan_reg, scan_next;
   logic              frame_reg, frame_next;
   logic [1:0]        sync_reg;
   logic              slot_last;
   logic              pressed;

   assign slot_last = (slot_cnt_reg == SLOT_LAST);
   assign pressed   = ~sync_reg[1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= SLOT0;
         slot_cnt_reg <= '0;
         scan_reg     <= 3'b110;
         frame_reg    <= 1'b0;
         sync_reg     <= 2'b11;
      end else begin
         state_reg    <= state_next;
         slot_cnt_reg <= slot_cnt_next;
         scan_reg     <= scan_next;
         frame_reg    <= frame_next;
         sync_reg     <= {sync_reg[0], i_sense};
      end
   end

   // Scan drive and frame strobe are computed one cycle early so both come straight from flops.
   always_comb begin
      state_next    = state_reg;
      slot_cnt_next = slot_cnt_reg + CW'(1);
      scan_next     = scan_reg;
      frame_next    = 1'b0;
      if (slot_last) begin
         slot_cnt_next = '0;
         case (state_reg)
            SLOT0: begin
               state_next = SLOT1;
               scan_next  = 3'b101;
            end
            SLOT1: begin
               state_next = SLOT2;
               scan_next  = 3'b011;
            end
            default: begin
               state_next = SLOT0;
               scan_next  = 3'b110;
            end
         endcase
      end
      if (state_reg == SLOT2 && slot_cnt_reg == SLOT_PRE) begin
         frame_next = 1'b1;
      end
   end

   assign o_scan  = scan_reg;
   assign o_frame = frame_reg;

   genvar gi;
   generate
      for (gi = 0; gi < N_KEYS; gi++) begin : g_key
         logic [DW-1:0] mis_reg;
         logic          stable_reg;
         logic          pulse_reg;
         logic          sample_en;
         logic          differs;
         logic          toggle;
         logic          rep_fire;

         assign sample_en = slot_last && (state_reg == 2'(gi));
         assign differs   = (pressed != stable_reg);
         assign toggle    = sample_en && differs && (mis_reg == DEB_LAST);

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               mis_reg    <= '0;
               stable_reg <= 1'b0;
               pulse_reg  <= 1'b0;
            end else begin
               pulse_reg <= (toggle && !stable_reg) || rep_fire;
               if (sample_en) begin
                  if (!differs) begin
                     mis_reg <= '0;
                  end else if (mis_reg == DEB_LAST) begin
                     stable_reg <= ~stable_reg;
                     mis_reg    <= '0;
                  end else begin
                     mis_reg <= mis_reg + DW'(1);
                  end
               end
            end
         end

`ifdef KEY_AUTOREPEAT_EN
         localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
         localparam int RW   = $clog2(RMAX + 1);
         localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY);
         localparam logic [RW-1:0] R_RATE  = RW'(REPEAT_RATE);

         logic [RW-1:0] rep_cnt_reg;
         logic [RW-1:0] rep_cnt_inc;
         logic          rep_first_reg;

         assign rep_cnt_inc = rep_cnt_reg + RW'(1);
         assign rep_fire    = sample_en && stable_reg && !toggle &&
                              (rep_cnt_inc == (rep_first_reg ? R_DELAY : R_RATE));

         // Counter sits at zero while released, so the accepting sample starts the count from scratch.
         always_ff @(posedge clk) begin
            if (!rst_n || !stable_reg || toggle) begin
               rep_cnt_reg   <= '0;
               rep_first_reg <= 1'b1;
            end else if (sample_en) begin
               if (rep_fire) begin
                  rep_cnt_reg   <= '0;
                  rep_first_reg <= 1'b0;
               end else begin
                  rep_cnt_reg <= rep_cnt_inc;
               end
            end
         end
`else
         assign rep_fire = 1'b0;
`endif

         assign o_key_state[gi] = stable_reg;
         assign o_key_pulse[gi] = pulse_reg;
      end
   endgenerate

endmodule

// File: tb/tb_key_scan_pulse.sv
// Scoreboard bench for key_scan_pulse: stimulus queues expected pulses, a monitor pops and compares.
// Build with KEY_AUTOREPEAT_EN defined to also expect repeat pulses.
module tb_key_scan_pulse;

   localparam int SD = 4;
   localparam int DS = 3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] keys  = 3'b000;
   logic       i_sense;
   logic [2:0] o_scan;
   logic [2:0] o_key_state;
   logic [2:0] o_key_pulse;
   logic       o_frame;

   // Key matrix: the sense line is pulled low by any closed key whose scan line is driven low.
   assign i_sense = ~|(keys & ~o_scan);

   key_scan_pulse #(
      .N_KEYS      (3),
      .SCAN_DIV    (SD),
      .DEB_SAMPLES (DS)
`ifdef KEY_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY(4),
      .REPEAT_RATE (2)
`endif
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_sense    (i_sense),
      .o_scan     (o_scan),
      .o_key_state(o_key_state),
      .o_key_pulse(o_key_pulse),
      .o_frame    (o_frame)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

   typedef struct {
      int         cyc;
      logic [2:0] pulse;
      logic [2:0] state;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   mon_en   = 1'b0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
      end
   endfunction

   function automatic logic [2:0] scan_exp(input int c);
      case ((c / SD) % 3)
         0:       return 3'b110;
         1:       return 3'b101;
         default: return 3'b011;
      endcase
   endfunction

   task automatic push(input int c, input logic [2:0] p, input logic [2:0] s);
      exp_t e;
      e.cyc   = c;
      e.pulse = p;
      e.state = s;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int c);
      int guard = 0;
      while (cyc != c) begin
         @(negedge clk);
         guard++;
         if (guard > 2000) begin
            check("wait_timeout", cyc, c);
            return;
         end
      end
   endtask

   // Leaves the bench at the negedge of cycle 0 (first cycle after release).
   task automatic do_reset(input logic [2:0] k);
      @(negedge clk);
      rst_n = 1'b0;
      keys  = k;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain(input string name);
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_scan"},  o_scan,      3'b110);
      check({tag, "_state"}, o_key_state, 3'b000);
      check({tag, "_pulse"}, o_key_pulse, 3'b000);
      check({tag, "_frame"}, o_frame,     1'b0);
   endtask

   // Monitor: every nonzero pulse vector must match the head of the expectation queue.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (mon_en && o_key_pulse !== 3'b000) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", o_key_pulse, 3'b000);
         end else begin
            e = exp_q.pop_front();
            check("pulse_cycle", cyc, e.cyc);
            check("pulse_vec",   o_key_pulse, e.pulse);
            check("pulse_state", o_key_state, e.state);
            $display("pulse cycle %0d vec %b state %b (expected cycle %0d vec %b)",
                     cyc, o_key_pulse, o_key_state, e.cyc, e.pulse);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset(3'b000);
      mon_en = 1'b1;
      check_reset_outputs("rst");

      // Single press of key 0, then release at cycle 36.
      do_reset(3'b001);
      push(28, 3'b001, 3'b001);
      for (int c = 0; c <= 70; c++) begin
         wait_cyc(c);
         check("scan_seq", o_scan, scan_exp(c));
         check("frame", o_frame, (c % 12) == 11);
         if (c == 27) check("k0_before_accept", o_key_state[0], 1'b0);
         if (c == 28) check("k0_accepted", o_key_state[0], 1'b1);
         if (c == 63) check("k0_still_held", o_key_state[0], 1'b1);
         if (c == 64) check("k0_released", o_key_state[0], 1'b0);
         if (c == 36) keys = 3'b000;
      end
      drain("single_queue");

      // Key 1 bounces: pressed on even frames, released on odd frames, 10 frames.
      do_reset(3'b000);
      for (int c = 0; c < 130; c++) begin
         wait_cyc(c);
         if (c % 12 == 0) keys[1] = (c / 12 < 10) && ((c / 12) % 2 == 0);
         check("bounce_state", o_key_state[1], 1'b0);
         check("bounce_pulse", o_key_pulse[1], 1'b0);
      end
      keys = 3'b000;
      drain("bounce_queue");

      // Keys 0 and 2 held together: pulses one slot pair apart.
      do_reset(3'b101);
      push(28, 3'b001, 3'b001);
      push(36, 3'b100, 3'b101);
      wait_cyc(60);
      check("simul_state", o_key_state, 3'b101);
      drain("simul_queue");

      // Reset while key 0 is accepted and still held.
      do_reset(3'b001);
      push(28, 3'b001, 3'b001);
      wait_cyc(40);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_reset_outputs("midrst");
      push(28, 3'b001, 3'b001);
      wait_cyc(27);
      check("midrst_pre_accept", o_key_state[0], 1'b0);
      wait_cyc(45);
      drain("midrst_queue");

      // Long hold of key 0.
      do_reset(3'b001);
      push(28, 3'b001, 3'b001);
`ifdef KEY_AUTOREPEAT_EN
      push(76,  3'b001, 3'b001);
      push(100, 3'b001, 3'b001);
      push(124, 3'b001, 3'b001);
`endif
      wait_cyc(130);
      check("hold_state", o_key_state, 3'b001);
      drain("hold_queue");
      keys = 3'b000;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
